seq_detect_multi: RTL and testbench

//   Multi-pattern serial sequence detector for the assignment datapath library.

---
 rtl/seq_detect_multi.sv | 171 +++++++++++++++++
 tb/tb_seq_detect_multi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_multi.sv
// ---------------------------------------------------------------------------
// seq_detect_multi
//   Serial sequence detector that checks one qualified bit stream against P
//   independent patterns. Each pattern has its own runtime length (1..N bits,
//   longer values clamp to N, 0 never matches) and its own enable. Results are
//   registered: per-pattern match pulses, their OR, the lowest matching
//   pattern index and a saturating count of match cycles.
//
//   Handshake: a bit is consumed on every rising clk edge where in_valid = 1
//   and clear = 0. There is no back-pressure, so the block is always ready.
//   Idle cycles hold history/fill and zero the match outputs.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous clear of history, fill, count and outputs
//   in_valid     qualifies a
//   a            serial data bit (becomes the newest history bit, LSB)
//   overlap      1 = overlapping detection, 0 = flush history on any match
//   pat_en       per-pattern enable
//   pat_seq      pattern p at [p*N +: N], newest bit in the LSB
//   pat_len      length of pattern p at [p*LW +: LW]
//   match        per-pattern one-cycle match pulse
//   match_any    OR of match
//   match_id     lowest index with match set, 0 when none
//   match_count  saturating count of cycles with match_any = 1
//   filled       fill counter has reached N
// ---------------------------------------------------------------------------
module seq_detect_multi #(
  parameter int N  = 8,
  parameter int P  = 4,
  parameter int CW = 8,
  localparam int LW = $clog2(N + 1),
  localparam int IW = (P > 1) ? $clog2(P) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic            a,
  input  logic            overlap,
  input  logic [P-1:0]    pat_en,
  input  logic [P*N-1:0]  pat_seq,
  input  logic [P*LW-1:0] pat_len,
  output logic [P-1:0]    match,
  output logic            match_any,
  output logic [IW-1:0]   match_id,
  output logic [CW-1:0]   match_count,
  output logic            filled
);

  // Only the N-1 most recent bits are stored: the oldest bit of an N-bit
  // history is shifted out before it could ever take part in a compare.
  logic [N-2:0]  hist_q, hist_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [P-1:0]  match_q, match_d;
  logic          match_any_q, match_any_d;
  logic [IW-1:0] match_id_q, match_id_d;
  logic [CW-1:0] match_count_q, match_count_d;
  logic          filled_q, filled_d;

  // Compare-side signals for the bit presented this cycle.
  logic [N-1:0]  nh;
  logic [LW-1:0] nf;
  logic [LW-1:0] leff [P];
  logic [P-1:0]  mism;
  logic [P-1:0]  hit;
  logic          hit_any;
  logic [IW-1:0] hit_id;

  // -------------------------------------------------------------------------
  // Pattern compare: history as it would look after accepting a, checked
  // against the low leff bits of every pattern. Configuration is used live.
  // -------------------------------------------------------------------------
  always_comb begin
    nh   = {hist_q, a};
    nf   = (fill_q == LW'(N)) ? fill_q : fill_q + LW'(1);
    mism = '0;
    hit  = '0;
    for (int p = 0; p < P; p++) begin
      leff[p] = pat_len[p*LW +: LW];
      if (leff[p] > LW'(N)) begin
        leff[p] = LW'(N);
      end
      // Bits at or above leff are ignored; a mismatch below it kills the hit.
      for (int i = 0; i < N; i++) begin
        if ((LW'(i) < leff[p]) && (nh[i] != pat_seq[p*N + i])) begin
          mism[p] = 1'b1;
        end
      end
      hit[p] = pat_en[p] && (leff[p] != '0) && (nf >= leff[p]) && !mism[p];
    end
  end

  // Lowest index wins: scan from the top so lower indices overwrite.
  always_comb begin
    hit_any = |hit;
    hit_id  = '0;
    for (int p = P - 1; p >= 0; p--) begin
      if (hit[p]) begin
        hit_id = IW'(p);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    hist_d        = hist_q;
    fill_d        = fill_q;
    match_d       = '0;
    match_any_d   = 1'b0;
    match_id_d    = '0;
    match_count_d = match_count_q;

    if (clear) begin
      // The bit presented alongside clear is dropped.
      hist_d        = '0;
      fill_d        = '0;
      match_count_d = '0;
    end else if (in_valid) begin
      match_d     = hit;
      match_any_d = hit_any;
      match_id_d  = hit_id;
      if (hit_any && (match_count_q != {CW{1'b1}})) begin
        match_count_d = match_count_q + CW'(1);
      end
      if (overlap || !hit_any) begin
        hist_d = nh[N-2:0];
        fill_d = nf;
      end else begin
        // Non-overlap: one flush serves every pattern that hit.
        hist_d = '0;
        fill_d = '0;
      end
    end

    filled_d = (fill_d == LW'(N));
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q        <= '0;
      fill_q        <= '0;
      match_q       <= '0;
      match_any_q   <= 1'b0;
      match_id_q    <= '0;
      match_count_q <= '0;
      filled_q      <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      match_q       <= match_d;
      match_any_q   <= match_any_d;
      match_id_q    <= match_id_d;
      match_count_q <= match_count_d;
      filled_q      <= filled_d;
    end
  end

  assign match       = match_q;
  assign match_any   = match_any_q;
  assign match_id    = match_id_q;
  assign match_count = match_count_q;
  assign filled      = filled_q;

endmodule

// File: tb/tb_seq_detect_multi.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_multi
//   Directed scenarios with literal expectations, then randomized traffic.
//   A queue-based model tracks the accepted bits and predicts every output;
//   a compare process checks both DUT instances against it each cycle.
//   The second instance uses CW=2 to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_seq_detect_multi;
  localparam int N  = 8;
  localparam int P  = 4;
  localparam int LW = $clog2(N + 1);
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            clear;
  logic            in_valid;
  logic            a;
  logic            overlap;
  logic [P-1:0]    pat_en;
  logic [P*N-1:0]  pat_seq;
  logic [P*LW-1:0] pat_len;

  logic [P-1:0]    match,  match2;
  logic            match_any, match_any2;
  logic [IW-1:0]   match_id, match_id2;
  logic [7:0]      match_count;
  logic [1:0]      match_count2;
  logic            filled, filled2;

  seq_detect_multi #(.N(N), .P(P), .CW(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .a(a),
    .overlap(overlap), .pat_en(pat_en), .pat_seq(pat_seq), .pat_len(pat_len),
    .match(match), .match_any(match_any), .match_id(match_id),
    .match_count(match_count), .filled(filled)
  );

  seq_detect_multi #(.N(N), .P(P), .CW(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .a(a),
    .overlap(overlap), .pat_en(pat_en), .pat_seq(pat_seq), .pat_len(pat_len),
    .match(match2), .match_any(match_any2), .match_id(match_id2),
    .match_count(match_count2), .filled(filled2)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist holds accepted bits, newest at index 0; its size is the fill level.
  bit          m_hist[$];
  logic [P-1:0] exp_match;
  logic         exp_any;
  logic [IW-1:0] exp_id;
  logic [7:0]   exp_cnt;
  logic [1:0]   exp_cnt2;
  logic         exp_filled;
  logic [P-1:0] m_hits;
  int           m_leff;
  bit           m_ok;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) begin
      m_hist.delete();
      exp_match = '0; exp_any = 1'b0; exp_id = '0;
      exp_cnt = '0; exp_cnt2 = '0;
    end else if (in_valid) begin
      m_hist.push_front(a);
      if (m_hist.size() > N) void'(m_hist.pop_back());
      m_hits = '0;
      for (int p = 0; p < P; p++) begin
        m_leff = int'(pat_len[p*LW +: LW]);
        if (m_leff > N) m_leff = N;
        if (pat_en[p] && m_leff > 0 && m_hist.size() >= m_leff) begin
          m_ok = 1'b1;
          for (int k = 0; k < m_leff; k++)
            if (m_hist[k] != pat_seq[p*N + k]) m_ok = 1'b0;
          m_hits[p] = m_ok;
        end
      end
      exp_match = m_hits;
      exp_any   = |m_hits;
      exp_id    = '0;
      for (int p = P - 1; p >= 0; p--) if (m_hits[p]) exp_id = IW'(p);
      if (exp_any) begin
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        if (exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 2'd1;
        if (!overlap) m_hist.delete();
      end
    end else begin
      exp_match = '0; exp_any = 1'b0; exp_id = '0;
    end
    exp_filled = (m_hist.size() == N);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("match",       32'(match),        32'(exp_match));
      chk("match_any",   32'(match_any),    32'(exp_any));
      chk("match_id",    32'(match_id),     32'(exp_id));
      chk("match_count", 32'(match_count),  32'(exp_cnt));
      chk("filled",      32'(filled),       32'(exp_filled));
      chk("sat_count",   32'(match_count2), 32'(exp_cnt2));
      chk("sat_match",   32'(match2),       32'(exp_match));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic b);
    in_valid = 1'b1;
    a        = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic cfg(input int p, input logic en, input int len, input int seq);
    pat_en[p]            = en;
    pat_len[p*LW +: LW]  = LW'(len);
    pat_seq[p*N +: N]    = N'(seq);
  endtask

  task automatic cfg_off();
    pat_en = '0; pat_len = '0; pat_seq = '0;
  endtask

  task automatic send_stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; a = 1'b0; overlap = 1'b1;
    cfg_off();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_match", 32'(match), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_filled", 32'(filled), 0);

    // Overlapping 101 on 1,0,1,0,1
    cfg(0, 1'b1, 3, 3'b101); overlap = 1'b1;
    send(1); chk("t1_b1", 32'(match), 0);
    send(0);
    send(1); chk("t1_b3", 32'(match), 4'b0001);
    send(0); chk("t1_b4", 32'(match), 0);
    send(1); chk("t1_b5", 32'(match), 4'b0001);
    chk("t1_cnt", 32'(match_count), 2);

    // Non-overlapping
    do_clear(); overlap = 1'b0;
    send(1); send(0);
    send(1); chk("t2_b3", 32'(match), 4'b0001);
    send(0);
    send(1); chk("t2_b5", 32'(match), 0);
    chk("t2_cnt", 32'(match_count), 1);

    // Length-8 pattern A5, partial then full
    do_clear(); overlap = 1'b1; cfg_off(); cfg(1, 1'b1, 8, 8'hA5);
    send_stream(16'h0025, 7);
    chk("t3_part", 32'(match), 0);
    chk("t3_part_filled", 32'(filled), 0);
    do_clear();
    send_stream(16'h00A5, 8);
    chk("t3_full", 32'(match), 4'b0010);
    chk("t3_id", 32'(match_id), 1);
    chk("t3_filled", 32'(filled), 1);

    // Simultaneous hits
    do_clear(); cfg_off(); cfg(0, 1'b1, 2, 2'b11); cfg(2, 1'b1, 3, 3'b111);
    send(1);
    send(1); chk("t4_b2", 32'(match), 4'b0001);
    send(1); chk("t4_b3", 32'(match), 4'b0101);
    chk("t4_id", 32'(match_id), 0);
    chk("t4_cnt", 32'(match_count), 2);

    // Gaps between bits
    do_clear(); cfg_off(); cfg(0, 1'b1, 3, 3'b101);
    send(1); idle(3); send(0); idle(3);
    send(1); chk("t5_b3", 32'(match), 4'b0001);
    idle(1); chk("t5_pulse", 32'(match), 0);
    idle(2); send(0); idle(3);
    send(1); chk("t5_b5", 32'(match), 4'b0001);
    chk("t5_cnt", 32'(match_count), 2);

    // Mid-stream clear
    do_clear();
    send(1); send(0); do_clear();
    send(1); chk("t6_clr", 32'(match), 0);

    // Length clamp: 12 behaves as 8
    do_clear(); cfg_off(); cfg(3, 1'b1, 12, 8'hFF);
    send_stream(16'h007F, 7); chk("t7_7", 32'(match), 0);
    send(1); chk("t7_8", 32'(match), 4'b1000);
    chk("t7_id", 32'(match_id), 3);

    // Saturation: five matches
    do_clear(); cfg_off(); cfg(0, 1'b1, 3, 3'b101); overlap = 1'b1;
    send_stream(16'h0555, 11);
    chk("t8_cnt", 32'(match_count), 5);
    chk("t8_sat", 32'(match_count2), 3);

    // Asynchronous reset while a pulse is present
    do_clear();
    send(1); send(0); send(1);
    #2 reset_n = 1'b0;
    #1;
    chk("t9_match", 32'(match), 0);
    chk("t9_any", 32'(match_any), 0);
    chk("t9_cnt", 32'(match_count), 0);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        for (int p = 0; p < P; p++) begin
          pat_en[p] = ($urandom_range(0, 3) != 0);
          pat_len[p*LW +: LW] = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15))
                                                            : LW'($urandom_range(1, 4));
          pat_seq[p*N +: N] = N'($urandom_range(0, 255));
        end
        overlap = 1'($urandom_range(0, 1));
      end
      in_valid = ($urandom_range(0, 3) != 0);
      a        = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; clear = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
